instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, req/ack instruction fetch, IR and decode.
// Define IFU_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              W_IM,
    input  logic              W_PC,
    input  logic              JUMP_TAKEN,
    input  logic [ADDR_W-1:0] JUMP_ADDR,
    output logic              IM_REQ,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic              IM_ACK,
    input  logic [31:0]       IM_RDATA,
    output logic [ADDR_W-1:0] PC,
    output logic              IR_VALID,
    output logic              STALL,
    output logic              PC_ERR,
    output logic [2:0]        TYPE,
    output logic [4:0]        op,
    output logic [3:0]        RD,
    output logic [3:0]        RA,
    output logic [3:0]        RB,
    output logic [15:0]       IMM
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LOADED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       ir_q, ir_d;
    logic              irv_q, irv_d;
    logic              err_q, err_d;

`ifdef IFU_PREFETCH_EN
    logic              pbv_q, pbv_d;
    logic [ADDR_W-1:0] pbt_q, pbt_d;
    logic [31:0]       pbd_q, pbd_d;
    logic              spec_q, spec_d;
    logic              stale_q, stale_d;
`endif

    assign pc_inc = pc_q + ONE;

    // Next-state and next-register values for every control/datapath register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        irv_d   = irv_q;
        err_d   = err_q;
`ifdef IFU_PREFETCH_EN
        pbv_d   = pbv_q;
        pbt_d   = pbt_q;
        pbd_d   = pbd_q;
        spec_d  = spec_q;
        stale_d = stale_q;
`endif
        unique case (state_q)
            FETCH: begin
                if (W_PC) begin
                    err_d = 1'b1;
                end
                if (IM_ACK) begin
`ifdef IFU_PREFETCH_EN
                    if (stale_q) begin
                        // stale speculative word retired; reissue at PC
                        addr_d  = pc_q;
                        stale_d = 1'b0;
                    end else begin
                        ir_d    = IM_RDATA;
                        irv_d   = 1'b1;
                        req_d   = 1'b0;
                        state_d = LOADED;
                        if (!(pbv_q && pbt_q == pc_inc)) begin
                            req_d  = 1'b1;
                            addr_d = pc_inc;
                            spec_d = 1'b1;
                        end
                    end
`else
                    ir_d    = IM_RDATA;
                    irv_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = LOADED;
`endif
                end
            end
            IDLE, LOADED: begin
                if (W_PC) begin
                    pc_d    = JUMP_TAKEN ? JUMP_ADDR : pc_inc;
                    irv_d   = 1'b0;
                    state_d = IDLE;
`ifdef IFU_PREFETCH_EN
                    if (JUMP_TAKEN) begin
                        pbv_d = 1'b0;
                    end
`endif
                end
`ifdef IFU_PREFETCH_EN
                if (spec_q && IM_ACK) begin
                    req_d  = 1'b0;
                    spec_d = 1'b0;
                    if (addr_q == pc_d || addr_q == pc_d + ONE) begin
                        pbv_d = 1'b1;
                        pbt_d = addr_q;
                        pbd_d = IM_RDATA;
                    end
                end
                if (W_IM) begin
                    if (pbv_d && pbt_d == pc_d) begin
                        ir_d    = pbd_d;
                        irv_d   = 1'b1;
                        pbv_d   = 1'b0;
                        state_d = LOADED;
                        if (!spec_d) begin
                            req_d  = 1'b1;
                            addr_d = pc_d + ONE;
                            spec_d = 1'b1;
                        end
                    end else if (spec_d) begin
                        // adopt the outstanding request as the demand fetch
                        state_d = FETCH;
                        irv_d   = 1'b0;
                        spec_d  = 1'b0;
                        stale_d = (addr_q != pc_d);
                    end else begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_d;
                        irv_d   = 1'b0;
                    end
                end
`else
                if (W_IM) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                    irv_d   = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, request, IR and error registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q   <= RESET_PC;
            req_q  <= 1'b0;
            addr_q <= RESET_PC;
            ir_q   <= '0;
            irv_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            req_q  <= req_d;
            addr_q <= addr_d;
            ir_q   <= ir_d;
            irv_q  <= irv_d;
            err_q  <= err_d;
        end
    end

`ifdef IFU_PREFETCH_EN
    // Prefetch buffer and speculative-request tracking.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pbv_q   <= 1'b0;
            pbt_q   <= '0;
            pbd_q   <= '0;
            spec_q  <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            pbv_q   <= pbv_d;
            pbt_q   <= pbt_d;
            pbd_q   <= pbd_d;
            spec_q  <= spec_d;
            stale_q <= stale_d;
        end
    end
`endif

    assign IM_REQ   = req_q;
    assign IM_ADDR  = addr_q;
    assign PC       = pc_q;
    assign IR_VALID = irv_q;
    assign STALL    = (state_q == FETCH);
    assign PC_ERR   = err_q;
    assign TYPE     = ir_q[31:29];
    assign op       = ir_q[28:24];
    assign RD       = ir_q[23:20];
    assign RA       = ir_q[19:16];
    assign RB       = ir_q[15:12];
    assign IMM      = ir_q[15:0];

endmodule
